// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the button sequencer and serializer
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic [7:0] DEF_BASE_CHAR = 8'h61;
    localparam logic [7:0] DEF_IDLE_CHAR = 8'h2E;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: valid/ready byte to UART frame transmitter (START, 8 data LSB first, optional PARITY, STOP)
// Ports: clk_i, rst_n_i (async active-low), i_valid/i_data/o_ready byte handshake,
//        o_serial line (idle high), o_active (start..stop), o_done (1-cycle pulse after stop).
// Macro UART_TX_PARITY_EN adds an even parity bit between data and stop.
module uart_tx_serializer import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_serial,
    output logic       o_active,
    output logic       o_done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    tx_state_t      r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic           r_serial, r_active, r_done, w_end;
`ifdef UART_TX_PARITY_EN
    logic           r_par;
`endif
    assign w_end    = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign o_ready  = r_state == IDLE;
    assign o_serial = r_serial;
    assign o_active = r_active;
    assign o_done   = r_done;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_serial <= UART_IDLE_LEVEL;
            r_active <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_cnt  <= (r_state == IDLE || w_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                IDLE: if (i_valid) begin
                    r_state  <= START;
                    r_shift  <= i_data;
                    r_serial <= 1'b0;
                    r_active <= 1'b1;
`ifdef UART_TX_PARITY_EN
                    r_par    <= ^i_data;
`endif
                end
                START: if (w_end) begin
                    r_state  <= DATA;
                    r_serial <= r_shift[0];
                    r_idx    <= '0;
                end
                DATA: if (w_end) begin
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        r_state  <= PARITY;
                        r_serial <= r_par;
`else
                        r_state  <= STOP;
                        r_serial <= UART_IDLE_LEVEL;
`endif
                    end else begin
                        r_serial <= r_shift[1];
                        r_shift  <= r_shift >> 1;
                        r_idx    <= r_idx + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_end) begin
                    r_state  <= STOP;
                    r_serial <= UART_IDLE_LEVEL;
                end
`endif
                STOP: if (w_end) begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_btn_tx_seq.sv
// uart_btn_tx_seq: debounced button presses and idle heartbeats queued in a FIFO and sent over UART
// Ports: clk_i, rst_n_i (async active-low), button_i raw buttons, uart_tx_data_o/active_o/done_o
//        serial line and status, fifo_full_o queue full, drop_o 1-cycle pulse on a lost character.
// Macro UART_TX_PARITY_EN (in uart_tx_serializer) selects 8E1 frames instead of 8N1.
module uart_btn_tx_seq import uart_pkg::*; #(
    parameter int         NUM_BUTTONS     = 4,
    parameter int         CLKS_PER_BIT    = 434,
    parameter int         FIFO_DEPTH      = 8,
    parameter int         DEBOUNCE_CYCLES = 250_000,
    parameter logic [7:0] BASE_CHAR       = DEF_BASE_CHAR,
    parameter int         IDLE_SEND_RATE  = 150_000_000,
    parameter logic [7:0] IDLE_CHAR       = DEF_IDLE_CHAR
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_BUTTONS-1:0] button_i,
    output logic                   uart_tx_data_o,
    output logic                   uart_tx_active_o,
    output logic                   uart_tx_done_o,
    output logic                   fifo_full_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [NUM_BUTTONS-1:0] r_s1, r_s2, r_lvl, r_arm, r_pend, w_acc, w_clr;
    logic [DW-1:0]          r_db [NUM_BUTTONS];
    logic [1:0]             r_vld;
    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wp, r_rp;
    logic [AW:0]            r_cnt;
    logic [3:0]             w_idx;
    logic [7:0]             w_wdata;
    logic                   r_drop, w_req, w_hb, w_wr_req, w_wr, w_rd, w_empty, w_ready, w_quiet;
    always_comb begin
        w_idx = '0;
        w_acc = '0;
        for (int k = NUM_BUTTONS - 1; k >= 0; k--) if (r_pend[k]) w_idx = 4'(k);
        for (int k = 0; k < NUM_BUTTONS; k++)
            w_acc[k] = (r_s2[k] != r_lvl[k]) && (r_db[k] == DW'(DEBOUNCE_CYCLES - 1));
    end
    assign w_req       = |r_pend;
    assign w_clr       = w_req ? NUM_BUTTONS'(1) << w_idx : '0;
    assign w_wr_req    = w_req | w_hb;
    assign w_wdata     = w_req ? BASE_CHAR + 8'(w_idx) : IDLE_CHAR;
    assign fifo_full_o = r_cnt == (AW + 1)'(FIFO_DEPTH);
    assign w_empty     = r_cnt == '0;
    assign w_wr        = w_wr_req & ~fifo_full_o;
    assign w_rd        = w_ready & ~w_empty;
    assign w_quiet     = w_empty & w_ready & ~w_req & ~|r_lvl;
    assign drop_o      = r_drop;
    // r_arm blocks a press edge until the button has been seen released after reset,
    // so a button held through reset never queues a character.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            {r_s1, r_s2, r_lvl, r_arm, r_pend} <= '0;
            r_vld  <= '0;
            r_drop <= 1'b0;
            for (int k = 0; k < NUM_BUTTONS; k++) r_db[k] <= '0;
        end else begin
            r_s1   <= button_i;
            r_s2   <= r_s1;
            r_vld  <= {r_vld[0], 1'b1};
            r_arm  <= r_arm | ({NUM_BUTTONS{r_vld[1]}} & ~r_s2 & ~r_lvl);
            r_pend <= (r_pend & ~w_clr) | (w_acc & r_s2 & r_arm);
            r_drop <= w_wr_req & fifo_full_o;
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                if (w_acc[k]) r_lvl[k] <= r_s2[k];
                r_db[k] <= (w_acc[k] || r_s2[k] == r_lvl[k]) ? '0 : r_db[k] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= w_wdata;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_rd);
        end
    end
    if (IDLE_SEND_RATE > 0) begin : g_hb
        localparam int HW = $clog2(IDLE_SEND_RATE + 1);
        logic [HW-1:0] r_hb;
        assign w_hb = w_quiet && r_hb == HW'(IDLE_SEND_RATE - 1);
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) r_hb <= '0;
            else r_hb <= (!w_quiet || w_hb) ? '0 : r_hb + 1'b1;
        end
    end else begin : g_no_hb
        assign w_hb = 1'b0;
    end
    uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_valid  (~w_empty),
        .i_data   (r_mem[r_rp]),
        .o_ready  (w_ready),
        .o_serial (uart_tx_data_o),
        .o_active (uart_tx_active_o),
        .o_done   (uart_tx_done_o)
    );
endmodule
